wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the async FIFO; the write-side counterpart of the read-pointer/empty logic. It keeps the binary and Gray write pointers and produces the memory write address and gated write enable. From the twice-synchronised Gray read pointer it derives full, almost-full, fill level and a sticky overflow flag. All logic runs in the write clock domain.

Parameters:
ADDRSIZE, 4, memory address width; FIFO depth = 2^ADDRSIZE; must be >= 2.
AF_THRESH, 2^ADDRSIZE-2, fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.

Ports:
wclk  input  1  write-domain clock; all state updates on its rising edge.
wrst  input  1  reset, synchronous, active-high.
winc  input  1  write request from producer.
wq2_rptr  input  ADDRSIZE+1  Gray read pointer after the 2-flop synchroniser into wclk.
wovf_clr  input  1  clears woverflow.
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
wen  output  1  memory write enable = winc & ~wfull (combinational).
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (wrst=1 at a wclk edge): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Overrides all other activity, including mid-burst or while full. waddr=0 and wen=winc after reset.
- Next-state terms:
  - wbnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
  - wgnext = (wbnext>>1) ^ wbnext.
- Each edge: wbin<=wbnext, wptr<=wgnext. The pointer advances only on an accepted write, and wptr changes at most one bit per cycle.
- Full: wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). Full asserts on the same edge as the write that fills the FIFO. Deassertion lags wq2_rptr by one wclk cycle; there is no combinational path from wq2_rptr to wfull.
- Read-pointer decode: rbin_s = Gray-to-binary of wq2_rptr (MSB copied, each lower bit = XOR of all higher Gray bits).
- Level: lvl_next = (wbnext - rbin_s) modulo 2^(ADDRSIZE+1), so wrap of either pointer is handled. wlevel <= lvl_next.
- Almost full: walmost_full <= (lvl_next >= AF_THRESH). When wfull=1, wlevel=2^ADDRSIZE and walmost_full=1.
- Overflow: woverflow <= (winc & wfull) | (woverflow & ~wovf_clr). If set and clear occur in the same cycle, set wins. A rejected write never moves wbin or wptr and never asserts wen.
- The level is conservative: the read pointer seen here is stale by the synchroniser latency, so wlevel may over-report but never under-report.
- wq2_rptr is assumed glitch-free Gray (one bit change per wclk). No checking is performed.

Test Plan:
- Reset: hold wrst=1 for 2 cycles with winc=1 → wptr=0, waddr=0, wfull=0, wlevel=0, woverflow=0; wptr does not move during reset.
- Fill: ADDRSIZE=4, wq2_rptr=0, winc=1 for 16 cycles → waddr steps 0..15. walmost_full=1 after the 14th accepted write. After the 16th: wfull=1, wlevel=16, wptr=5'b11000 (Gray of 16).
- Overflow: with the FIFO full, winc=1 for 1 cycle → wen=0, wptr stays 5'b11000, woverflow=1 next edge. Then wovf_clr=1 and winc=1 in the same cycle → woverflow stays 1. Then wovf_clr=1 with winc=0 → woverflow=0.
- Drain release: from full, set wq2_rptr=5'b00110 (Gray 4) → the edge after: wfull=0, wlevel=12, walmost_full=0. A write then gives wlevel=13.
- Wrap: reader tracks writer with lag 2; issue 40 writes → wbin wraps 31→0, wptr passes 5'b10000→5'b00000, and wptr changes exactly 1 bit per accepted write. wlevel stays 2, wfull never asserts.
- Reset mid-operation: assert wrst while wfull=1 and woverflow=1 → the next edge clears all outputs to the reset values. The first write after reset produces waddr=0, then wptr=5'b00001.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller for an async FIFO.
// Holds binary/Gray write pointers, gates writes when full, and reports level, almost-full and overflow.
module wptr_full_ctrl #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AF_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AF_LEVEL = AF_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              woverflow_q, woverflow_d;

  logic              accept;
  logic [ADDRSIZE:0] wbnext;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_ptr;
  logic [ADDRSIZE:0] lvl_next;

  // Gray-to-binary: each binary bit is the XOR of that Gray bit and all above it.
  always_comb begin
    rbin_s = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    accept   = winc & ~wfull_q;
    wbnext   = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wgnext   = (wbnext >> 1) ^ wbnext;
    full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    lvl_next = wbnext - rbin_s;
  end

  always_comb begin
    wbin_d         = wbnext;
    wptr_d         = wgnext;
    wfull_d        = (wgnext == full_ptr);
    wlevel_d       = lvl_next;
    walmost_full_d = (lvl_next >= AF_LEVEL);
    // Set wins over clear when both happen in the same cycle.
    woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wptr         = wptr_q;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wen          = accept;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: count-based FIFO model checked every cycle, plus directed literal checks.
module tb_wptr_full_ctrl;
  localparam int A     = 4;
  localparam int DEPTH = 1 << A;

  logic         wclk = 1'b0;
  logic         wrst = 1'b0;
  logic         winc = 1'b0;
  logic [A:0]   wq2_rptr = '0;
  logic         wovf_clr = 1'b0;
  logic [A:0]   wptr;
  logic [A-1:0] waddr;
  logic         wen;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wlevel;
  logic         woverflow;

  int checks = 0;
  int errors = 0;

  wptr_full_ctrl #(.ADDRSIZE(A), .AF_THRESH(DEPTH - 2)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .wptr(wptr), .waddr(waddr), .wen(wen), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  // Model in terms of counts: writes accepted, reads done by the far side.
  int m_wb = 0;
  int rcnt = 0;
  int m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  bit chk_en = 0;

  function automatic logic [A:0] gray(input int b);
    logic [A:0] v;
    v = b[A:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge wclk) begin
    if (wrst) begin
      m_wb = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
      chk_en = 1;
    end else begin
      m_ovf = (winc && m_full) || (m_ovf && !wovf_clr);
      if (winc && !m_full) m_wb = m_wb + 1;
      m_lvl  = (m_wb - rcnt) & (2 * DEPTH - 1);
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= DEPTH - 2);
    end
  end

  always @(negedge wclk) begin
    if (chk_en) begin
      chk("wptr", 32'(wptr), 32'(gray(m_wb)));
      chk("waddr", 32'(waddr), 32'(m_wb & (DEPTH - 1)));
      chk("wen", 32'(wen), 32'(winc && !m_full));
      chk("wfull", 32'(wfull), 32'(m_full));
      chk("walmost_full", 32'(walmost_full), 32'(m_af));
      chk("wlevel", 32'(wlevel), 32'(m_lvl));
      chk("woverflow", 32'(woverflow), 32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_r(input int r);
    rcnt     = r;
    wq2_rptr = gray(r);
  endtask

  task automatic do_reset();
    wrst = 1; winc = 0; wovf_clr = 0; set_r(0);
    cyc();
    wrst = 0;
  endtask

  logic [A:0] prev;
  bit seen_wrap;
  int w;

  initial begin
    // Reset held two cycles with writes requested
    wrst = 1; winc = 1; set_r(0);
    cyc();
    cyc();
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_wovf", 32'(woverflow), 0);
    wrst = 0;

    // Fill 16 entries with reader parked at 0
    winc = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      cyc();
      if (i == DEPTH - 4) chk("af_before", 32'(walmost_full), 0);
      if (i == DEPTH - 3) chk("af_at14", 32'(walmost_full), 1);
    end
    chk("full_wfull", 32'(wfull), 1);
    chk("full_wlevel", 32'(wlevel), 16);
    chk("full_wptr", 32'(wptr), 32'h18);

    // Overflow, then set-vs-clear priority, then clear
    chk("ovf_wen", 32'(wen), 0);
    cyc();
    chk("ovf_wptr", 32'(wptr), 32'h18);
    chk("ovf_set", 32'(woverflow), 1);
    wovf_clr = 1;
    cyc();
    chk("ovf_setwins", 32'(woverflow), 1);
    winc = 0;
    cyc();
    chk("ovf_clr", 32'(woverflow), 0);
    wovf_clr = 0;

    // Drain release
    set_r(4);
    chk("drain_rptr", 32'(wq2_rptr), 32'h06);
    cyc();
    chk("drain_wfull", 32'(wfull), 0);
    chk("drain_wlevel", 32'(wlevel), 12);
    chk("drain_af", 32'(walmost_full), 0);
    winc = 1;
    cyc();
    chk("drain_w13", 32'(wlevel), 13);
    winc = 0;

    // Wrap with reader lagging by two
    do_reset();
    seen_wrap = 0;
    winc = 1;
    for (int i = 0; i < 40; i++) begin
      w = m_wb;
      set_r(w > 0 ? w - 1 : 0);
      prev = wptr;
      cyc();
      chk("wrap_1bit", 32'($countones(prev ^ wptr)), 1);
      chk("wrap_nofull", 32'(wfull), 0);
      if (i >= 1) chk("wrap_lvl2", 32'(wlevel), 2);
      if (prev == 5'b10000 && wptr == 5'b00000) seen_wrap = 1;
    end
    chk("wrap_seen", 32'(seen_wrap), 1);
    winc = 0;

    // Reset while full and overflowed
    do_reset();
    winc = 1;
    for (int i = 0; i < DEPTH + 1; i++) cyc();
    chk("mid_full", 32'(wfull), 1);
    chk("mid_ovf", 32'(woverflow), 1);
    wrst = 1;
    cyc();
    chk("mid_wptr", 32'(wptr), 0);
    chk("mid_wfull", 32'(wfull), 0);
    chk("mid_wlevel", 32'(wlevel), 0);
    chk("mid_wovf", 32'(woverflow), 0);
    chk("mid_af", 32'(walmost_full), 0);
    wrst = 0; set_r(0);
    chk("post_waddr", 32'(waddr), 0);
    chk("post_wen", 32'(wen), 1);
    cyc();
    chk("post_wptr", 32'(wptr), 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        wrst = 1; winc = 1; set_r(0);
      end else begin
        wrst = 0;
        winc = ($urandom_range(0, 3) != 0);
        wovf_clr = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0 && rcnt < m_wb) set_r(rcnt + 1);
      end
      cyc();
    end
    wrst = 0; winc = 0; wovf_clr = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
